// File: rtl/led_p2s_sched.sv
// Schedules LED words from two round-robin requesters plus a periodic refresh onto
// a single parallel-to-serial shifter, with a launch/busy handshake and busy-rise timeout.
module led_p2s_sched #(
    parameter int unsigned DATA_BITS      = 16,
    parameter int unsigned REFRESH_CYCLES = 1024,
    parameter int unsigned BUSY_TIMEOUT   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req0_i,
    input  logic [DATA_BITS-1:0] data0_i,
    input  logic                 req1_i,
    input  logic [DATA_BITS-1:0] data1_i,
    input  logic                 refresh_en_i,
    input  logic                 p2s_busy_i,
    output logic                 p2s_start_o,
    output logic [DATA_BITS-1:0] p2s_data_o,
    output logic                 ack0_o,
    output logic                 ack1_o,
    output logic [1:0]           grant_o,
    output logic                 timeout_err_o
);

    typedef enum logic [2:0] {StIdle, StLaunch, StWaitHi, StWaitLo, StAck} state_e;

    localparam logic [15:0]     RefreshReload = 16'(REFRESH_CYCLES - 1);
    localparam int unsigned     TmoW          = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast       = TmoW'(BUSY_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic                   last_q, last_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [15:0]            rcnt_q, rcnt_d;
    logic [TmoW-1:0]        tcnt_q, tcnt_d;
    logic                   terr_q, terr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= 2'b00;
            last_q  <= 1'b1;
            data_q  <= '0;
            rcnt_q  <= RefreshReload;
            tcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
            rcnt_q  <= rcnt_d;
            tcnt_q  <= tcnt_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        rcnt_d  = rcnt_q;
        tcnt_d  = tcnt_q;
        terr_d  = terr_q;
        unique case (state_q)
            StIdle: begin
                if (rcnt_q != '0) begin
                    rcnt_d = rcnt_q - 1'b1;
                end
                // last_q=1 means requester 1 was served last, so requester 0 wins a tie
                if (req0_i && (!req1_i || last_q)) begin
                    owner_d = 2'b01;
                    data_d  = data0_i;
                    state_d = StLaunch;
                end else if (req1_i) begin
                    owner_d = 2'b10;
                    data_d  = data1_i;
                    state_d = StLaunch;
                end else if (refresh_en_i && rcnt_q == '0) begin
                    owner_d = 2'b00;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                tcnt_d  = TmoW'(1);
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (p2s_busy_i) begin
                    state_d = StWaitLo;
                end else if (tcnt_q >= TmoLast) begin
                    terr_d  = 1'b1;
                    state_d = StAck;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!p2s_busy_i) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                rcnt_d = RefreshReload;
                if (owner_q == 2'b01) begin
                    last_d = 1'b0;
                end else if (owner_q == 2'b10) begin
                    last_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (!refresh_en_i) begin
            rcnt_d = RefreshReload;
        end
    end

    always_comb begin
        p2s_start_o   = (state_q == StLaunch);
        ack0_o        = (state_q == StAck) && owner_q[0];
        ack1_o        = (state_q == StAck) && owner_q[1];
        grant_o       = (state_q == StIdle) ? 2'b00 : owner_q;
        p2s_data_o    = data_q;
        timeout_err_o = terr_q;
    end

endmodule

// File: tb/tb_led_p2s_sched.sv
// Bench for led_p2s_sched: a timestamp-based transfer model checked every cycle,
// a configurable shifter stand-in, and directed scenarios with literal expectations.
module tb_led_p2s_sched;

    localparam int unsigned DW  = 16;
    localparam int unsigned RC  = 8;
    localparam int unsigned BT  = 4;

    localparam int SelG0    = 0;
    localparam int SelG1    = 1;
    localparam int SelAck0  = 2;
    localparam int SelAck1  = 3;
    localparam int SelStart = 4;
    localparam int SelAnyG  = 5;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req0, req1, refresh_en, busy;
    logic [DW-1:0] data0, data1;
    logic          p2s_start_o, ack0_o, ack1_o, timeout_err_o;
    logic [DW-1:0] p2s_data_o;
    logic [1:0]    grant_o;

    int tests = 0;
    int fails = 0;

    // Shifter stand-in controls.
    int sh_lat   = 0;
    int sh_len   = 1;
    bit sh_never = 0;

    led_p2s_sched #(
        .DATA_BITS      (DW),
        .REFRESH_CYCLES (RC),
        .BUSY_TIMEOUT   (BT)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req0_i        (req0),
        .data0_i       (data0),
        .req1_i        (req1),
        .data1_i       (data1),
        .refresh_en_i  (refresh_en),
        .p2s_busy_i    (busy),
        .p2s_start_o   (p2s_start_o),
        .p2s_data_o    (p2s_data_o),
        .ack0_o        (ack0_o),
        .ack1_o        (ack1_o),
        .grant_o       (grant_o),
        .timeout_err_o (timeout_err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Shifter: busy rises sh_lat+1 cycles after the launch cycle and stays sh_len cycles.
    initial begin
        int  wait_n;
        int  rem;
        bit  st;
        busy   = 1'b0;
        wait_n = 0;
        rem    = 0;
        forever begin
            @(negedge clk_i);
            st = p2s_start_o;
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                wait_n = 0;
                rem    = 0;
                busy   = 1'b0;
            end else begin
                if (st && !sh_never) wait_n = sh_lat + 1;
                if (wait_n > 0) begin
                    wait_n--;
                    if (wait_n == 0) rem = sh_len;
                end
                busy = (rem > 0);
                if (rem > 0) rem--;
            end
        end
    end

    // Transfer-level model: each transfer is a launch time, the time busy was first
    // seen, and the resulting ack time; outputs follow from those timestamps.
    initial begin
        int         cyc, t_launch, t_hi, t_ack, idle_seen;
        bit         m_act, m_last, m_err, m_tmo;
        logic [1:0] m_own;
        logic [DW-1:0] m_word;
        logic       e_start, e_a0, e_a1;
        logic [1:0] e_grant;
        cyc = 0; m_act = 0; m_last = 1; m_err = 0; m_tmo = 0; idle_seen = 0;
        m_own = 2'b00; m_word = '0; t_launch = 0; t_hi = -1; t_ack = -1;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                m_act = 0; m_last = 1; m_err = 0; m_tmo = 0; idle_seen = 0; m_word = '0;
                e_start = 0; e_grant = 2'b00; e_a0 = 0; e_a1 = 0;
            end else begin
                if (m_act && cyc == t_ack && m_tmo) m_err = 1;
                e_start = m_act && (cyc == t_launch);
                e_grant = m_act ? m_own : 2'b00;
                e_a0    = m_act && (cyc == t_ack) && (m_own == 2'b01);
                e_a1    = m_act && (cyc == t_ack) && (m_own == 2'b10);
            end
            chk("model p2s_start", p2s_start_o, e_start);
            chk("model grant", grant_o, e_grant);
            chk("model ack0", ack0_o, e_a0);
            chk("model ack1", ack1_o, e_a1);
            chk("model p2s_data", p2s_data_o, m_word);
            chk("model timeout_err", timeout_err_o, m_err);
            if (rst_ni) begin
                if (m_act) begin
                    if (cyc == t_ack) begin
                        m_act = 0;
                        if (m_own == 2'b01) m_last = 0;
                        else if (m_own == 2'b10) m_last = 1;
                        idle_seen = 0;
                    end else if (cyc > t_launch && t_hi < 0 && t_ack < 0) begin
                        if (busy) t_hi = cyc;
                        else if (cyc - t_launch >= int'(BT) - 1) begin
                            t_ack = cyc + 1;
                            m_tmo = 1;
                        end
                    end else if (t_hi >= 0 && cyc > t_hi && t_ack < 0 && !busy) begin
                        t_ack = cyc + 1;
                    end
                end else begin
                    bit win;
                    win = 1;
                    if (req0 && (!req1 || m_last)) begin
                        m_own = 2'b01; m_word = data0;
                    end else if (req1) begin
                        m_own = 2'b10; m_word = data1;
                    end else if (refresh_en && idle_seen >= int'(RC) - 1) begin
                        m_own = 2'b00;
                    end else begin
                        win = 0;
                    end
                    if (win) begin
                        m_act = 1; t_launch = cyc + 1; t_hi = -1; t_ack = -1; m_tmo = 0;
                    end
                    idle_seen++;
                end
                if (!refresh_en) idle_seen = 0;
            end
        end
    end

    function automatic bit cond(input int sel);
        case (sel)
            SelG0:    return grant_o == 2'b01;
            SelG1:    return grant_o == 2'b10;
            SelAck0:  return ack0_o == 1'b1;
            SelAck1:  return ack1_o == 1'b1;
            SelStart: return p2s_start_o == 1'b1;
            SelAnyG:  return grant_o != 2'b00;
            default:  return 1'b0;
        endcase
    endfunction

    // Entered at a negedge; returns the number of cycles until the condition holds.
    task automatic wait_cond(input int sel, input int budget, input string nm, output int n);
        n = 0;
        while (!cond(sel) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (!cond(sel)) begin
            tests++;
            fails++;
            $display("FAIL %s: event not seen, required within %0d cycles", nm, budget);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " p2s_start"}, p2s_start_o, 1'b0);
        chk({nm, " grant"}, grant_o, 2'b00);
        chk({nm, " ack0"}, ack0_o, 1'b0);
        chk({nm, " ack1"}, ack1_o, 1'b0);
        chk({nm, " p2s_data"}, p2s_data_o, 16'h0000);
        chk({nm, " timeout_err"}, timeout_err_o, 1'b0);
    endtask

    // Ends at a drive point (just after a rising edge) with reset released.
    task automatic do_reset();
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("reset");
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_ni = 1'b0; req0 = 0; req1 = 0; refresh_en = 0; data0 = '0; data1 = '0;

        // Single requester-0 transfer, 16-cycle busy starting two cycles after launch.
        do_reset();
        sh_lat = 1; sh_len = 16; sh_never = 0;
        req0 = 1; data0 = 16'hA55A;
        @(negedge clk_i);
        wait_cond(SelG0, 10, "t1 grant", n);
        chk("t1 grant latency", n, 1);
        chk("t1 start at launch", p2s_start_o, 1'b1);
        chk("t1 data", p2s_data_o, 16'hA55A);
        wait_cond(SelAck0, 40, "t1 ack0", n);
        chk("t1 grant-to-ack0 cycles", n, 19);
        @(posedge clk_i); #1; req0 = 0;

        // Tied requests held: served 0,1,0,1 with minimum latency and one IDLE between.
        do_reset();
        sh_lat = 0; sh_len = 1;
        req0 = 1; req1 = 1; data0 = 16'h1111; data1 = 16'h2222;
        @(negedge clk_i);
        for (int k = 0; k < 4; k++) begin
            wait_cond(SelAnyG, 10, "t2 grant", n);
            chk("t2 idle-to-launch gap", n, 1);
            chk("t2 rr grant", grant_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2 rr data", p2s_data_o, (k % 2 == 0) ? 16'h1111 : 16'h2222);
            wait_cond((k % 2 == 0) ? SelAck0 : SelAck1, 10, "t2 ack", n);
            chk("t2 min grant-to-ack", n, 3);
            @(negedge clk_i);
        end
        // Fifth transfer (requester 0) already launching; dropping req must not abort it.
        @(posedge clk_i); #1; req0 = 0; req1 = 0;
        @(negedge clk_i);
        wait_cond(SelAck0, 10, "t2 dropped-req ack0", n);
        @(posedge clk_i); #1;

        // Busy never rises: timeout after BUSY_TIMEOUT cycles, sticky error.
        do_reset();
        sh_never = 1;
        req0 = 1; data0 = 16'h5A5A;
        @(negedge clk_i);
        wait_cond(SelG0, 10, "t3 grant", n);
        chk("t3 grant latency", n, 1);
        wait_cond(SelAck0, 20, "t3 ack0", n);
        chk("t3 launch-to-ack cycles", n, 4);
        chk("t3 timeout_err at ack", timeout_err_o, 1'b1);
        @(posedge clk_i); #1; req0 = 0; sh_never = 0; sh_lat = 0; sh_len = 3;
        repeat (5) @(negedge clk_i);
        chk("t3 timeout_err sticky", timeout_err_o, 1'b1);
        @(posedge clk_i); #1; req0 = 1;
        @(negedge clk_i);
        wait_cond(SelAck0, 20, "t3 second ack0", n);
        chk("t3 timeout_err after good transfer", timeout_err_o, 1'b1);
        @(posedge clk_i); #1; req0 = 0;

        // Refresh re-sends the last word every REFRESH_CYCLES idle cycles.
        do_reset();
        refresh_en = 1; sh_lat = 0; sh_len = 2;
        req1 = 1; data1 = 16'h002A;
        @(negedge clk_i);
        wait_cond(SelG1, 10, "t4 grant", n);
        chk("t4 grant latency", n, 1);
        wait_cond(SelAck1, 20, "t4 ack1", n);
        @(posedge clk_i); #1; req1 = 0; data1 = 16'hFFFF;
        @(negedge clk_i);
        wait_cond(SelStart, 30, "t4 first refresh", n);
        chk("t4 first refresh delay", n, 8);
        chk("t4 refresh grant", grant_o, 2'b00);
        chk("t4 refresh data", p2s_data_o, 16'h002A);
        @(negedge clk_i);
        wait_cond(SelStart, 30, "t4 second refresh", n);
        chk("t4 refresh period", n, 12);
        chk("t4 second refresh data", p2s_data_o, 16'h002A);
        @(posedge clk_i); #1; refresh_en = 0;

        // Reset in WAIT_LO: outputs clear at once, no ack, then a fresh transfer.
        do_reset();
        sh_lat = 0; sh_len = 6;
        req0 = 1; data0 = 16'h0F0F;
        @(negedge clk_i);
        wait_cond(SelG0, 10, "t5 grant", n);
        repeat (3) @(negedge clk_i);
        chk("t5 grant held in WAIT_LO", grant_o, 2'b01);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("t5 async reset");
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        wait_cond(SelG0, 10, "t5 regrant", n);
        chk("t5 regrant latency", n, 1);
        chk("t5 regrant data", p2s_data_o, 16'h0F0F);
        wait_cond(SelAck0, 20, "t5 ack0", n);
        @(posedge clk_i); #1; req0 = 0;

        // req1 arriving during a req0 transfer launches two cycles after ack0.
        do_reset();
        sh_lat = 0; sh_len = 4;
        req0 = 1; data0 = 16'h1234;
        @(negedge clk_i);
        wait_cond(SelG0, 10, "t6 grant0", n);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1; req1 = 1; data1 = 16'h4321;
        @(negedge clk_i);
        wait_cond(SelAck0, 20, "t6 ack0", n);
        @(posedge clk_i); #1; req0 = 0;
        @(negedge clk_i);
        wait_cond(SelG1, 10, "t6 grant1", n);
        chk("t6 ack0-to-launch1 gap", n + 1, 2);
        chk("t6 req1 data", p2s_data_o, 16'h4321);
        wait_cond(SelAck1, 20, "t6 ack1", n);
        @(posedge clk_i); #1; req1 = 0;
        repeat (3) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
